peripheral_bfm_master_generic_axi4: RTL and testbench



---
 rtl/peripheral_axi4_pkg.sv | 35 +++
 rtl/peripheral_bfm_timeout_axi4.sv | 34 +++
 rtl/peripheral_bfm_master_generic_axi4.sv | 231 +++++++++++++++++++++++
 tb/tb_peripheral_bfm_master_generic_axi4.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_axi4_pkg.sv
// peripheral_axi4_pkg
//   Shared AXI4 encodings and helpers for the peripheral BFMs.
//   Contents:
//     AXI_BURST_INCR, AXI_RESPONSE_OKAY, AXI_RESPONSE_SLVERR  - channel encodings
//     axi_mst_state_e                                          - master BFM FSM states
//     axi_wstrb(size, addr_lsb)                                - byte strobe for one beat
package peripheral_axi4_pkg;

  localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
  localparam logic [1:0] AXI_RESPONSE_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESPONSE_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    MST_IDLE    = 3'd0,
    MST_WR_ADDR = 3'd1,
    MST_WR_DATA = 3'd2,
    MST_WR_RESP = 3'd3,
    MST_RD_ADDR = 3'd4,
    MST_RD_DATA = 3'd5
  } axi_mst_state_e;

  // Strobe for a beat at byte address lsbs addr_lsb. Halfword beats are
  // aligned down to the containing halfword; word beats enable every lane.
  function automatic logic [3:0] axi_wstrb(input logic [1:0] size,
                                           input logic [1:0] addr_lsb);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lsb;
      2'd1:    strb = 4'b0011 << {addr_lsb[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/peripheral_bfm_timeout_axi4.sv
// peripheral_bfm_timeout_axi4
//   Wait-cycle counter for one handshake. Counts cycles since the last clear
//   and saturates; expired is high in the TIMEOUT-th cycle of waiting.
//   Ports:
//     aclk    in  clock
//     areset  in  synchronous active-high reset
//     clear   in  restart the count (handshake, state change or idle)
//     expired out current cycle is the last one allowed to wait
module peripheral_bfm_timeout_axi4 #(
  parameter int TIMEOUT = 256
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  // count is 0 in the first waiting cycle, so LIMIT is reached in cycle TIMEOUT.
  assign expired = (count == LIMIT);

endmodule

// File: rtl/peripheral_bfm_master_generic_axi4.sv
// peripheral_bfm_master_generic_axi4
//   AXI4 master BFM: executes one single-word command at a time as an INCR
//   write or read burst and reports per-beat (read) or per-burst (write)
//   responses. Any handshake waiting TIMEOUT cycles aborts the command.
//   Ports:
//     aclk, areset                      clock, synchronous active-high reset
//     cmd_valid/cmd_ready, cmd_*        command from the sequencer
//     rsp_valid, rsp_data, rsp_resp,    registered response pulse
//     rsp_last, rsp_err
//     aw*/w*/b*, ar*/r*                 AXI4 master channels
//     dbg_state                         current FSM state (axi_mst_state_e)
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; a valid, once raised, holds it and its payload unchanged until
//   that edge. Payload outputs read 0 whenever their valid is low.
module peripheral_bfm_master_generic_axi4
  import peripheral_axi4_pkg::*;
#(
  parameter logic [3:0] ID      = 4'h0,
  parameter int         TIMEOUT = 256
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic [3:0]  awid,
  output logic [31:0] awadr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wrdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [2:0]  dbg_state
);

  axi_mst_state_e state_q, state_d;

  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [1:0]  size_q;       // clamped: sizes above 2 behave as 2
  logic [31:0] data_q;
  logic [3:0]  beat_q;
  logic [31:0] beat_addr_q;

  logic cmd_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic last_beat, to_expired, to_clear, abort;

  peripheral_bfm_timeout_axi4 #(.TIMEOUT(TIMEOUT)) u_timeout (
    .aclk    (aclk),
    .areset  (areset),
    .clear   (to_clear),
    .expired (to_expired)
  );

  // Next state, handshake detection and channel outputs.
  always_comb begin
    state_d   = state_q;
    cmd_acc   = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    b_hs      = 1'b0;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;

    last_beat = (beat_q == len_q);

    case (state_q)
      MST_IDLE: begin
        // Hold off the next command while the final response is on rsp_*.
        cmd_ready = !rsp_valid;
        cmd_acc   = cmd_valid && !rsp_valid;
        if (cmd_acc) state_d = cmd_write ? MST_WR_ADDR : MST_RD_ADDR;
      end
      MST_WR_ADDR: begin
        awvalid = 1'b1;
        aw_hs   = awready;
        if (aw_hs) state_d = MST_WR_DATA;
      end
      MST_WR_DATA: begin
        wvalid = 1'b1;
        w_hs   = wready;
        if (w_hs && last_beat) state_d = MST_WR_RESP;
      end
      MST_WR_RESP: begin
        bready = 1'b1;
        b_hs   = bvalid;
        if (b_hs) state_d = MST_IDLE;
      end
      MST_RD_ADDR: begin
        arvalid = 1'b1;
        ar_hs   = arready;
        if (ar_hs) state_d = MST_RD_DATA;
      end
      MST_RD_DATA: begin
        rready = 1'b1;
        r_hs   = rvalid;
        if (r_hs && last_beat) state_d = MST_IDLE;
      end
      default: state_d = MST_IDLE;
    endcase

    any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    // A handshake in the expiring cycle still completes normally.
    abort  = (state_q != MST_IDLE) && to_expired && !any_hs;
    if (abort) state_d = MST_IDLE;
    to_clear = (state_q == MST_IDLE) || any_hs || (state_d != state_q);

    awid    = awvalid ? ID : 4'h0;
    awadr   = awvalid ? addr_q : 32'h0;
    awlen   = awvalid ? len_q : 4'h0;
    awsize  = awvalid ? {1'b0, size_q} : 3'd0;
    awburst = awvalid ? AXI_BURST_INCR : 2'b00;
    awlock  = 2'b00;
    awcache = 4'h0;
    awprot  = 3'd0;

    wid    = wvalid ? ID : 4'h0;
    wrdata = wvalid ? (data_q + {28'h0, beat_q}) : 32'h0;
    wstrb  = wvalid ? axi_wstrb(size_q, beat_addr_q[1:0]) : 4'h0;
    wlast  = wvalid && last_beat;

    arid    = arvalid ? ID : 4'h0;
    araddr  = arvalid ? addr_q : 32'h0;
    arlen   = arvalid ? len_q : 4'h0;
    arsize  = arvalid ? {1'b0, size_q} : 3'd0;
    arlock  = 2'b00;
    arcache = 4'h0;
    arprot  = 3'd0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= MST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      data_q      <= '0;
      beat_q      <= '0;
      beat_addr_q <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_resp    <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;

      if (cmd_acc) begin
        addr_q      <= cmd_addr;
        len_q       <= cmd_len;
        size_q      <= (cmd_size > 3'd2) ? 2'd2 : cmd_size[1:0];
        data_q      <= cmd_data;
        beat_q      <= '0;
        beat_addr_q <= cmd_addr;
      end else if (w_hs || r_hs) begin
        beat_q      <= beat_q + 1'b1;
        beat_addr_q <= beat_addr_q + (32'd1 << size_q);
      end

      if (abort) begin
        rsp_valid <= 1'b1;
        rsp_resp  <= AXI_RESPONSE_SLVERR;
        rsp_last  <= 1'b1;
        rsp_err   <= 1'b1;
      end else if (b_hs) begin
        rsp_valid <= 1'b1;
        rsp_resp  <= bresp;
        rsp_last  <= 1'b1;
        rsp_err   <= (bid != ID);
      end else if (r_hs) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rdata;
        rsp_resp  <= rresp;
        rsp_last  <= last_beat;
        // The burst length comes from the command; rlast is only cross-checked.
        rsp_err   <= (rid != ID) || (rlast != last_beat);
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_peripheral_bfm_master_generic_axi4.sv
// tb_peripheral_bfm_master_generic_axi4
//   Directed bench for the AXI4 master BFM: table of write/read commands
//   with hand-computed expectations, plus timeout and mid-burst reset cases.
module tb_peripheral_bfm_master_generic_axi4;

  localparam logic [3:0] ID  = 4'hA;
  localparam int         TMO = 8;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [3:0]  awid, awlen, awcache, wid, bid, arid, arlen, arcache, rid;
  logic [31:0] awadr, wrdata, araddr, rdata;
  logic [2:0]  awsize, awprot, arsize, arprot, dbg_state;
  logic [1:0]  awburst, awlock, bresp, arlock, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  peripheral_bfm_master_generic_axi4 #(.ID(ID), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [31:0] data;       // write seed, or read beat k returns data*(k+1)
    logic        toggle;     // wready alternates, starting low
    logic [3:0]  rlast_beat; // read beat on which the slave raises rlast
    logic [1:0]  resp;       // bresp / rresp returned by the slave
    logic [3:0]  sid;        // bid / rid returned by the slave
    logic        exp_err;    // write: rsp_err; read: ID-mismatch part of rsp_err
  } vec_t;

  vec_t vecs[8];

  // Byte-lane model: lanes covered by an n-byte beat aligned down within the word.
  function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [31:0] a);
    int n, base;
    logic [3:0] s;
    n    = (size >= 3'd2) ? 4 : (1 << size);
    base = int'(a[1:0]) & ~(n - 1);
    for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + n);
    return s;
  endfunction

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [31:0] data);
    @(negedge aclk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_len = len; cmd_size = size; cmd_data = data;
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic run_write(input vec_t v);
    logic [2:0] esz;
    int k, cyc;
    logic wr, wv;
    esz = (v.size > 3'd2) ? 3'd2 : v.size;
    send_cmd(1'b1, v.addr, v.len, v.size, v.data);
    chk("awvalid", awvalid, 1);
    chk("awadr", awadr, v.addr);
    chk("awlen", awlen, v.len);
    chk("awsize", awsize, esz);
    chk("awburst", awburst, 2'b01);
    chk("awid", awid, ID);
    chk("wvalid_before_aw", wvalid, 0);
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    chk("awvalid_drop", awvalid, 0);
    k = 0; cyc = 0;
    while (k <= int'(v.len) && cyc < 64) begin
      wv = wvalid;
      chk("wvalid", wvalid, 1);
      chk("wrdata", wrdata, v.data + 32'(k));
      chk("wstrb", wstrb, model_strb(esz, v.addr + (32'(k) << esz)));
      chk("wlast", wlast, k == int'(v.len));
      chk("wid", wid, ID);
      wr = v.toggle ? ((cyc % 2) == 1) : 1'b1;
      wready = wr;
      @(negedge aclk);
      if (wr && wv) k++;
      cyc++;
    end
    wready = 1'b0;
    chk("w_beat_count", 32'(k), 32'(v.len) + 1);
    chk("wvalid_after_last", wvalid, 0);
    chk("bready", bready, 1);
    bvalid = 1'b1; bid = v.sid; bresp = v.resp;
    @(negedge aclk);
    bvalid = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_resp", rsp_resp, v.resp);
    chk("wr_rsp_last", rsp_last, 1);
    chk("wr_rsp_err", rsp_err, v.exp_err);
    chk("wr_rsp_data", rsp_data, 0);
    chk("cmd_ready_final", cmd_ready, 0);
    chk("bready_drop", bready, 0);
    @(negedge aclk);
    chk("rsp_valid_pulse", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  task automatic run_read(input vec_t v);
    logic [2:0] esz;
    esz = (v.size > 3'd2) ? 3'd2 : v.size;
    send_cmd(1'b0, v.addr, v.len, v.size, v.data);
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, v.addr);
    chk("arlen", arlen, v.len);
    chk("arsize", arsize, esz);
    chk("arid", arid, ID);
    chk("awvalid_on_read", awvalid, 0);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 0);
    chk("rready", rready, 1);
    for (int k = 0; k <= int'(v.len); k++) begin
      rvalid = 1'b1; rdata = v.data * 32'(k + 1); rresp = v.resp;
      rid = v.sid; rlast = (k == int'(v.rlast_beat));
      @(negedge aclk);
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_data", rsp_data, v.data * 32'(k + 1));
      chk("rd_rsp_resp", rsp_resp, v.resp);
      chk("rd_rsp_last", rsp_last, k == int'(v.len));
      chk("rd_rsp_err", rsp_err,
          v.exp_err | ((k == int'(v.rlast_beat)) != (k == int'(v.len))));
      chk("rready_beat", rready, k != int'(v.len));
    end
    rvalid = 1'b0; rlast = 1'b0;
    chk("cmd_ready_final", cmd_ready, 0);
    @(negedge aclk);
    chk("rsp_valid_pulse", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    int n;
    areset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_data = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (3) @(negedge aclk);

    // Reset values
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_awid", awid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_state", dbg_state, 0);
    areset = 1'b0;

    //           wr    addr          len   size  data           tog   rlb   resp   sid   err
    vecs[0] = '{1'b1, 32'h0000_0010, 4'd0, 3'd2, 32'hA5A5_A5A5, 1'b0, 4'd0, 2'b00, ID,   1'b0};
    vecs[1] = '{1'b1, 32'h0000_0020, 4'd3, 3'd2, 32'h0000_0100, 1'b1, 4'd0, 2'b00, ID,   1'b0};
    vecs[2] = '{1'b1, 32'h0000_0003, 4'd1, 3'd0, 32'h0000_0055, 1'b0, 4'd0, 2'b00, ID,   1'b0};
    vecs[3] = '{1'b1, 32'h0000_0006, 4'd2, 3'd1, 32'hFFFF_FFFF, 1'b0, 4'd0, 2'b10, ID,   1'b0};
    vecs[4] = '{1'b1, 32'h0000_0000, 4'd0, 3'd5, 32'h1234_5678, 1'b0, 4'd0, 2'b00, 4'h3, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0040, 4'd2, 3'd2, 32'h0000_0011, 1'b0, 4'd2, 2'b00, ID,   1'b0};
    vecs[6] = '{1'b0, 32'h0000_0040, 4'd2, 3'd2, 32'h0000_0011, 1'b0, 4'd1, 2'b00, ID,   1'b0};
    vecs[7] = '{1'b0, 32'h0000_0052, 4'd0, 3'd1, 32'h0000_BEEF, 1'b0, 4'd0, 2'b01, 4'h5, 1'b1};

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) run_write(vecs[i]);
      else               run_read(vecs[i]);
    end

    // Timeout with awready stuck low: 8 cycles of awvalid, then abort.
    send_cmd(1'b1, 32'h80, 4'd0, 3'd2, 32'h0);
    n = 0;
    while (awvalid && n < 20) begin
      n++;
      @(negedge aclk);
    end
    chk("aw_timeout_cycles", 32'(n), TMO);
    chk("aw_to_rsp_valid", rsp_valid, 1);
    chk("aw_to_rsp_resp", rsp_resp, 2'b10);
    chk("aw_to_rsp_last", rsp_last, 1);
    chk("aw_to_rsp_err", rsp_err, 1);
    chk("aw_to_cmd_ready", cmd_ready, 0);
    @(negedge aclk);
    chk("aw_to_cmd_ready_after", cmd_ready, 1);
    chk("aw_to_rsp_pulse", rsp_valid, 0);

    // Timeout mid read burst: counter restarts after the last delivered beat.
    send_cmd(1'b0, 32'h90, 4'd3, 3'd2, 32'h0);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    rvalid = 1'b1; rid = ID; rresp = 2'b00; rlast = 1'b0; rdata = 32'h0000_0AAA;
    @(negedge aclk);
    rdata = 32'h0000_0BBB;
    @(negedge aclk);
    rvalid = 1'b0;
    chk("r_to_beat1_rsp", rsp_data, 32'h0000_0BBB);
    n = 0;
    while (rready && n < 20) begin
      n++;
      @(negedge aclk);
    end
    chk("r_timeout_cycles", 32'(n), TMO);
    chk("r_to_rsp_valid", rsp_valid, 1);
    chk("r_to_rsp_resp", rsp_resp, 2'b10);
    chk("r_to_rsp_err", rsp_err, 1);
    chk("r_to_rsp_last", rsp_last, 1);
    chk("r_to_rsp_data", rsp_data, 0);
    @(negedge aclk);

    // Reset during read beat 2: burst abandoned, no response.
    send_cmd(1'b0, 32'h40, 4'd2, 3'd2, 32'h0);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    rvalid = 1'b1; rid = ID; rdata = 32'h11; rlast = 1'b0;
    @(negedge aclk);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    rdata = 32'h22; areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    areset = 1'b0; rvalid = 1'b0;

    // Normal operation after the reset.
    run_write(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
